// File: rtl/stream_demux.sv
// stream_demux
// 1-to-2 stream router for datapath words. A word accepted on the
// valid/ready input is steered by in_select to port 0 (register file) or
// port 1 (load/store unit). Each port has its own 2-entry register FIFO.
// The FIFO gives full throughput. It also keeps out*_ready off the
// in_ready path.
//
// Ports:
//   clk, rst_n               system clock, synchronous active-low reset
//   in_valid/in_ready        input handshake
//   in_data, in_select       input word and its destination port
//   out0_valid/out0_ready    port 0 handshake, out0_data head word
//   out1_valid/out1_ready    port 1 handshake, out1_data head word
//   cnt0, cnt1               completed-transfer counters per port
//                            (present only when STREAM_DEMUX_CNT_EN is defined)
//
// Optional feature macro: STREAM_DEMUX_CNT_EN

module stream_demux #(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_select,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     out0_data,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [WIDTH-1:0]     out1_data
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
`endif
);

    logic [1:0]       count  [2];
    logic             rd_ptr [2];
    logic             wr_ptr [2];
    logic [WIDTH-1:0] mem    [2][2];

    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready_v;
    logic       sel_full;

    assign out_ready_v = {out1_ready, out0_ready};

    // Depends only on the select bit and registered occupancy. The consumer
    // ready signals never reach in_ready combinationally.
    assign sel_full = in_select ? (count[1] == 2'd2) : (count[0] == 2'd2);
    assign in_ready = rst_n & ~sel_full;

    always_comb begin
        push    = '0;
        pop     = '0;
        push[0] = in_valid & in_ready & ~in_select;
        push[1] = in_valid & in_ready &  in_select;
        pop[0]  = (count[0] != 2'd0) & out_ready_v[0];
        pop[1]  = (count[1] != 2'd0) & out_ready_v[1];
    end

    assign out0_valid = (count[0] != 2'd0);
    assign out1_valid = (count[1] != 2'd0);
    assign out0_data  = mem[0][rd_ptr[0]];
    assign out1_data  = mem[1][rd_ptr[1]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                count[p]  <= 2'd0;
                rd_ptr[p] <= 1'b0;
                wr_ptr[p] <= 1'b0;
                // Storage is cleared so both data outputs read 0 after reset.
                mem[p][0] <= '0;
                mem[p][1] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) begin
                    mem[p][wr_ptr[p]] <= in_data;
                    wr_ptr[p]         <= ~wr_ptr[p];
                end
                if (pop[p]) begin
                    rd_ptr[p] <= ~rd_ptr[p];
                end
                // A push and a pop in the same cycle leave occupancy unchanged.
                case ({push[p], pop[p]})
                    2'b10:   count[p] <= count[p] + 2'd1;
                    2'b01:   count[p] <= count[p] - 2'd1;
                    default: count[p] <= count[p];
                endcase
            end
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_WIDTH-1:0] xfer_cnt [2];

    // Counts completed output transfers. The count wraps naturally at
    // 2^CNT_WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt[0] <= '0;
            xfer_cnt[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (pop[p]) begin
                    xfer_cnt[p] <= xfer_cnt[p] + 1'b1;
                end
            end
        end
    end

    assign cnt0 = xfer_cnt[0];
    assign cnt1 = xfer_cnt[1];
`else
    // CNT_WIDTH only sizes the optional counters.
    logic unused_cnt_width;
    assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

    localparam int W  = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_select;
    logic          out0_valid;
    logic          out0_ready;
    logic [W-1:0]  out0_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [W-1:0]  out1_data;
`ifdef STREAM_DEMUX_CNT_EN
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] mc0;
    logic [CW-1:0] mc1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_demux #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_select  (in_select),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    // Behavioural reference: one queue per port, capacity 2.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    bit           after_rst = 1'b0;
    int           em0 = 0;
    int           em1 = 0;

    typedef struct {
        logic         iv;
        logic         sel;
        logic [W-1:0] d;
        logic         r0;
        logic         r1;
        logic         e_rdy;
        logic         e_v0;
        logic         e_v1;
        logic [W-1:0] e_d0;
        logic [W-1:0] e_d1;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic iv, logic sel, logic [W-1:0] d, logic r0, logic r1,
                                logic e_rdy, logic e_v0, logic e_v1,
                                logic [W-1:0] e_d0, logic [W-1:0] e_d1);
        vec_t v;
        v.iv = iv; v.sel = sel; v.d = d; v.r0 = r0; v.r1 = r1;
        v.e_rdy = e_rdy; v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_d0 = e_d0; v.e_d1 = e_d1;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk64(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic iv, input logic sel, input logic [W-1:0] d,
                         input logic r0, input logic r1);
        rst_n      = rst;
        in_valid   = iv;
        in_select  = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    function automatic logic model_ready();
        int n;
        n = in_select ? q1.size() : q0.size();
        return rst_n && (n != 2);
    endfunction

    task automatic model_check();
        chk1("in_ready", in_ready, model_ready());
        chk1("out0_valid", out0_valid, q0.size() != 0);
        chk1("out1_valid", out1_valid, q1.size() != 0);
        if (q0.size() != 0) chk64("out0_data", out0_data, q0[0]);
        else if (after_rst) chk64("out0_data_rst", out0_data, '0);
        if (q1.size() != 0) chk64("out1_data", out1_data, q1[0]);
        else if (after_rst) chk64("out1_data_rst", out1_data, '0);
`ifdef STREAM_DEMUX_CNT_EN
        chk64("cnt0", 64'(cnt0), 64'(mc0));
        chk64("cnt1", 64'(cnt1), 64'(mc1));
`endif
    endtask

    // Applies the edge to the model, then waits for the next negedge.
    task automatic model_tick();
        logic acc;
        logic p0;
        logic p1;
        if (out0_valid && out0_ready) em0++;
        if (out1_valid && out1_ready) em1++;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            after_rst = 1'b1;
`ifdef STREAM_DEMUX_CNT_EN
            mc0 = '0;
            mc1 = '0;
`endif
        end else begin
            acc = in_valid && model_ready();
            p0  = (q0.size() != 0) && out0_ready;
            p1  = (q1.size() != 0) && out1_ready;
            after_rst = 1'b0;
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
`ifdef STREAM_DEMUX_CNT_EN
            if (p0) mc0 = mc0 + 1'b1;
            if (p1) mc1 = mc1 + 1'b1;
`endif
            if (acc) begin
                if (in_select) q1.push_back(in_data);
                else           q0.push_back(in_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic rst, input logic iv, input logic sel, input logic [W-1:0] d,
                        input logic r0, input logic r1, input bit do_chk);
        drive(rst, iv, sel, d, r0, r1);
        #1;
        if (do_chk) model_check();
        model_tick();
    endtask

    initial begin
        // Routing then backpressure, starting from empty FIFOs.
        vecs[0]  = mk(1'b1, 1'b1, 64'd20, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 64'd0,  64'd0);
        vecs[1]  = mk(1'b1, 1'b0, 64'd40, 1'b1, 1'b1,  1'b1, 1'b0, 1'b1, 64'd0,  64'd20);
        vecs[2]  = mk(1'b0, 1'b0, 64'd0,  1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 64'd40, 64'd0);
        vecs[3]  = mk(1'b0, 1'b0, 64'd0,  1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 64'd0,  64'd0);
        vecs[4]  = mk(1'b1, 1'b0, 64'd10, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 64'd0,  64'd0);
        vecs[5]  = mk(1'b1, 1'b0, 64'd11, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 64'd10, 64'd0);
        vecs[6]  = mk(1'b1, 1'b0, 64'd12, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 64'd10, 64'd0);
        vecs[7]  = mk(1'b1, 1'b1, 64'd99, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 64'd10, 64'd0);
        vecs[8]  = mk(1'b1, 1'b0, 64'd12, 1'b1, 1'b1,  1'b0, 1'b1, 1'b1, 64'd10, 64'd99);
        vecs[9]  = mk(1'b1, 1'b0, 64'd12, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 64'd11, 64'd0);
        vecs[10] = mk(1'b0, 1'b0, 64'd0,  1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 64'd12, 64'd0);
        vecs[11] = mk(1'b0, 1'b0, 64'd0,  1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 64'd0,  64'd0);

`ifdef STREAM_DEMUX_CNT_EN
        mc0 = '0;
        mc1 = '0;
`endif

        // Reset held for 2 edges with in_valid high.
        step(1'b0, 1'b1, 1'b0, 64'd5, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 64'd5, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 64'd5, 1'b1, 1'b1);
        #1;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out0_valid", out0_valid, 1'b0);
        chk1("rst_out1_valid", out1_valid, 1'b0);
        chk64("rst_out0_data", out0_data, '0);
        chk64("rst_out1_data", out1_data, '0);
`ifdef STREAM_DEMUX_CNT_EN
        chk64("rst_cnt0", 64'(cnt0), 64'd0);
        chk64("rst_cnt1", 64'(cnt1), 64'd0);
`endif
        model_tick();

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].iv, vecs[i].sel, vecs[i].d, vecs[i].r0, vecs[i].r1);
            #1;
            chk1($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_rdy);
            chk1($sformatf("vec%0d_out0_valid", i), out0_valid, vecs[i].e_v0);
            chk1($sformatf("vec%0d_out1_valid", i), out1_valid, vecs[i].e_v1);
            if (vecs[i].e_v0) chk64($sformatf("vec%0d_out0_data", i), out0_data, vecs[i].e_d0);
            if (vecs[i].e_v1) chk64($sformatf("vec%0d_out1_data", i), out1_data, vecs[i].e_d1);
            model_tick();
        end

        // Throughput: 100 back-to-back words, alternating ports.
        em0 = 0;
        em1 = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b1, 1'(i % 2), 64'(1000 + i), 1'b1, 1'b1);
            #1;
            chk1($sformatf("tput%0d_in_ready", i), in_ready, 1'b1);
            model_check();
            model_tick();
        end
        step(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        chk64("tput_port0_count", 64'(em0), 64'd50);
        chk64("tput_port1_count", 64'(em1), 64'd50);

`ifdef STREAM_DEMUX_CNT_EN
        // Counter wrap: 17 transfers on a 4-bit counter land on 1.
        step(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, 64'(500 + i), 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        chk64("wrap_cnt0", 64'(cnt0), 64'd1);
        chk64("wrap_cnt1", 64'(cnt1), 64'd0);
`endif

        // Mid-operation reset with 2 words parked on port 1.
        step(1'b1, 1'b1, 1'b1, 64'hAAAA, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 64'hBBBB, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0);
        #1;
        chk1("mid_pre_out1_valid", out1_valid, 1'b1);
        chk1("mid_pre_in_ready", in_ready, 1'b0);
        model_tick();
        step(1'b0, 1'b1, 1'b1, 64'hCCCC, 1'b1, 1'b0, 1'b1);
        em1 = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
            #1;
            chk1($sformatf("mid_post%0d_out1_valid", i), out1_valid, 1'b0);
            model_tick();
        end
        chk64("mid_post_emitted", 64'(em1), 64'd0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 199) != 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 {$urandom, $urandom},
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
